// File: rtl/exe_pipe.sv
// Y86-64 execute stage: computes val_e and cnd, holds the condition codes,
// and runs an optional W-cycle shift-add multiplier behind a valid/ready handshake.
module exe_pipe #(
  parameter int W          = 64,
  parameter int STACK_STEP = 8,
  parameter int ENABLE_MUL = 1
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   in_icode,
  input  logic [3:0]   in_ifun,
  input  logic [W-1:0] val_a,
  input  logic [W-1:0] val_b,
  input  logic [W-1:0] val_c,
  input  logic         cc_inhibit,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] val_e,
  output logic         cnd,
  output logic [3:0]   out_icode,
  output logic [2:0]   cc
);

  localparam int CW = $clog2(W);

  typedef enum logic [0:0] {IDLE = 1'b0, MUL = 1'b1} state_t;

  state_t         state_r, state_next_s;
  logic [CW-1:0]  cnt_r;
  logic [W-1:0]   mcand_r, mplier_r, acc_r, acc_add_s;
  logic           mul_inh_r;
  logic           out_valid_r, cnd_r;
  logic [W-1:0]   val_e_r;
  logic [3:0]     out_icode_r;
  logic [2:0]     cc_r;

  logic           accept_s, start_mul_s, mul_done_s, load_s, cc_we_s;
  logic           alu_ok_s, alu_of_s, cond_s;
  logic [W-1:0]   alu_res_s, calc_val_e_s, load_val_e_s;
  logic [2:0]     load_flags_s;

  // Branch/move condition from the ifun and the currently registered {ZF,SF,OF}.
  function automatic logic eval_cond(input logic [3:0] fn, input logic [2:0] f);
    logic zf, sf, of;
    zf = f[2];
    sf = f[1];
    of = f[0];
    case (fn)
      4'd0:    eval_cond = 1'b1;
      4'd1:    eval_cond = (sf ^ of) | zf;
      4'd2:    eval_cond = sf ^ of;
      4'd3:    eval_cond = zf;
      4'd4:    eval_cond = ~zf;
      4'd5:    eval_cond = ~(sf ^ of);
      4'd6:    eval_cond = ~(sf ^ of) & ~zf;
      default: eval_cond = 1'b0;
    endcase
  endfunction

  // State register; reset aborts any multiply in flight.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_mul_s) state_next_s = MUL;
        else             state_next_s = IDLE;
      end
      MUL: begin
        if (cnt_r == {CW{1'b0}}) state_next_s = IDLE;
        else                     state_next_s = MUL;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // FSM outputs: acceptance, multiply start and multiply completion.
  always_comb begin
    in_ready    = reset_n && (state_r == IDLE) && (!out_valid_r || out_ready);
    accept_s    = in_valid && in_ready;
    start_mul_s = accept_s && (in_icode == 4'd6) && (in_ifun == 4'd4) && (ENABLE_MUL != 0);
    mul_done_s  = (state_r == MUL) && (cnt_r == {CW{1'b0}});
  end

  // ALU for OPq; A = val_b, B = val_a. Unknown functions yield 0 and leave CC alone.
  always_comb begin
    alu_ok_s  = 1'b1;
    alu_of_s  = 1'b0;
    alu_res_s = {W{1'b0}};
    case (in_ifun)
      4'd0: begin
        alu_res_s = val_b + val_a;
        alu_of_s  = (val_a[W-1] == val_b[W-1]) && (alu_res_s[W-1] != val_b[W-1]);
      end
      4'd1: begin
        alu_res_s = val_b - val_a;
        alu_of_s  = (val_b[W-1] != val_a[W-1]) && (alu_res_s[W-1] != val_b[W-1]);
      end
      4'd2:    alu_res_s = val_a & val_b;
      4'd3:    alu_res_s = val_a ^ val_b;
      default: alu_ok_s  = 1'b0;
    endcase
  end

  // val_e selection by icode and the condition flag for jXX/cmovXX.
  always_comb begin
    calc_val_e_s = {W{1'b0}};
    case (in_icode)
      4'd2:        calc_val_e_s = val_a;
      4'd3:        calc_val_e_s = val_c;
      4'd4, 4'd5:  calc_val_e_s = val_c + val_b;
      4'd6:        calc_val_e_s = alu_res_s;
      4'd8, 4'd10: calc_val_e_s = val_b - W'(STACK_STEP);
      4'd9, 4'd11: calc_val_e_s = val_b + W'(STACK_STEP);
      default:     calc_val_e_s = {W{1'b0}};
    endcase
    if ((in_icode == 4'd2) || (in_icode == 4'd7)) cond_s = eval_cond(in_ifun, cc_r);
    else                                          cond_s = 1'b0;
  end

  // Load of the output register and condition codes, from either source.
  always_comb begin
    acc_add_s = acc_r + (mplier_r[0] ? mcand_r : {W{1'b0}});
    load_s    = (accept_s && !start_mul_s) || mul_done_s;
    if (mul_done_s) begin
      load_val_e_s = acc_add_s;
      load_flags_s = {acc_add_s == {W{1'b0}}, acc_add_s[W-1], 1'b0};
      cc_we_s      = !mul_inh_r;
    end else begin
      load_val_e_s = calc_val_e_s;
      load_flags_s = {alu_res_s == {W{1'b0}}, alu_res_s[W-1], alu_of_s};
      cc_we_s      = accept_s && !start_mul_s && (in_icode == 4'd6) && alu_ok_s && !cc_inhibit;
    end
  end

  // Multiplier datapath: one shift-add step per cycle, counter W-1 down to 0.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cnt_r     <= {CW{1'b0}};
      mcand_r   <= {W{1'b0}};
      mplier_r  <= {W{1'b0}};
      acc_r     <= {W{1'b0}};
      mul_inh_r <= 1'b0;
    end else if (start_mul_s) begin
      cnt_r     <= CW'(W - 1);
      mcand_r   <= val_b;
      mplier_r  <= val_a;
      acc_r     <= {W{1'b0}};
      mul_inh_r <= cc_inhibit;
    end else if (state_r == MUL) begin
      cnt_r    <= cnt_r - CW'(1);
      mcand_r  <= mcand_r << 1;
      mplier_r <= mplier_r >> 1;
      acc_r    <= acc_add_s;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Output register and condition codes; holds while downstream stalls.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      out_valid_r <= 1'b0;
      val_e_r     <= {W{1'b0}};
      cnd_r       <= 1'b0;
      out_icode_r <= 4'd0;
      cc_r        <= 3'b100;
    end else begin
      if (load_s) begin
        out_valid_r <= 1'b1;
        val_e_r     <= load_val_e_s;
        cnd_r       <= mul_done_s ? 1'b0 : cond_s;
        out_icode_r <= mul_done_s ? 4'd6 : in_icode;
      end else if (out_valid_r && out_ready) begin
        out_valid_r <= 1'b0;
      end else begin
        out_valid_r <= out_valid_r;
      end
      if (cc_we_s) cc_r <= load_flags_s;
      else         cc_r <= cc_r;
    end
  end

  assign out_valid = out_valid_r;
  assign val_e     = val_e_r;
  assign cnd       = cnd_r;
  assign out_icode = out_icode_r;
  assign cc        = cc_r;

endmodule

// File: doc/exe_pipe.md
# exe_pipe

Parametrised, handshaked execute stage for the Y86-64 processor; successor to the single-cycle SEQ execute block. It computes `val_e` and the branch/move condition `cnd`, and holds the condition codes (ZF, SF, OF) in registers. It adds an optional iterative multiplier (OPq function 4) with back-pressure. It sits between decode and memory in the pipelined core, with valid/ready handshakes on both sides.

## Interface
- `W`, 64: datapath width (≥ 8, power of 2)
- `STACK_STEP`, 8: byte step for call/ret/push/pop
- `ENABLE_MUL`, 1: 1 = OPq ifun 4 is a W-cycle shift-add multiply; 0 = ifun 4 is treated as an undefined function
- `clock` in 1: single clock, rising edge
- `reset_n` in 1: synchronous, active-low reset
- `in_valid` in 1: decode presents an instruction
- `in_ready` out 1: stage accepts the instruction this cycle
- `in_icode` in 4, `in_ifun` in 4: instruction code and function
- `val_a`, `val_b`, `val_c` in W: operands
- `cc_inhibit` in 1: when 1 at acceptance, the OPq does not update CC (downstream exception)
- `out_valid` out 1; `out_ready` in 1: handshake toward memory
- `val_e` out W, `cnd` out 1, `out_icode` out 4: registered results
- `cc` out 3: {ZF, SF, OF}, the current registered condition codes

## Operation
- Acceptance occurs when `in_valid && in_ready`.
- `in_ready = reset_n && state==IDLE && (!out_valid || out_ready)`.
- `val_e` by icode:
  - 2: `val_a`
  - 3: `val_c`
  - 4, 5: `val_c + val_b`
  - 6: ALU result
  - 8, 10: `val_b - STACK_STEP`
  - 9, 11: `val_b + STACK_STEP`
  - all others (0, 1, 7, 12–15): 0
- Arithmetic is modulo 2^W.
- ALU operations (A = `val_b`, B = `val_a`):
  - ifun 0: b+a
  - ifun 1: b−a
  - ifun 2: a&b
  - ifun 3: a^b
  - ifun 4 with ENABLE_MUL: low W bits of a·b
  - other ifun: result 0, CC unchanged
- Flags:
  - ZF = (result == 0); SF = result[W−1].
  - OF for add: operands have the same sign and the result sign differs.
  - OF for sub: sign(b) ≠ sign(a) and sign(result) ≠ sign(b).
  - OF is 0 for and, xor and mul.
- `cnd` applies only for icode 2 and 7 and is evaluated on the CC registered at acceptance:
  - ifun 0: 1
  - ifun 1 (le): (SF^OF)|ZF
  - ifun 2 (l): SF^OF
  - ifun 3 (e): ZF
  - ifun 4 (ne): !ZF
  - ifun 5 (ge): !(SF^OF)
  - ifun 6 (g): !(SF^OF)&!ZF
  - other ifun, and all other icodes: 0
- CC is written on the same edge the OPq result loads the output register, only if the op is valid and `cc_inhibit` was 0 at acceptance.
- FSM:
  - IDLE → (accept OPq ifun 4, ENABLE_MUL) → MUL. Otherwise the result loads the output register on the accepting edge.
  - MUL: multiplicand, multiplier and accumulator registers, plus a counter from W−1 down to 0. Each cycle adds the shifted multiplicand if the multiplier LSB is 1.
  - MUL, counter==0 → IDLE: result and CC load on that edge and `out_valid` goes to 1.
- Output register:
  - Holds until `out_valid && out_ready`.
  - Clears `out_valid` on a hand-off edge with no new load.
  - Reloads on the same edge if a new instruction is accepted.

## Timing
- Reset (`reset_n` low at an edge):
  - `out_valid`=0, `val_e`=0, `cnd`=0, `out_icode`=0 (halt code).
  - `cc`=3'b100 (ZF=1).
  - state=IDLE, counter=0.
  - `in_ready`=0 while `reset_n` is low.
- Non-mul latency is 1: accept at edge k, `out_valid` high after edge k.
- Mul latency is W: accept at edge k, result after edge k+W; `in_ready`=0 for cycles k+1 … k+W.
- Back-to-back acceptance at 1 per cycle when `out_ready` is held 1.
- An OPq accepted at edge k updates CC at edge k. A jXX/cmov accepted at edge k+1 sees the new CC.
- Stall: when `out_ready`=0 with `out_valid`=1, `in_ready` drops. Outputs and CC stay stable.
- Reset mid-MUL aborts the multiply: no CC update and no output.

## Test plan
- Reset, then idle: `cc`=100, `out_valid`=0, `val_e`=0. `in_ready` rises the first cycle after `reset_n` goes high.
- OPq sub, a=5, b=5 → `val_e`=0, `cc`=100. A following jXX ifun 3 (e) gives `cnd`=1; ifun 4 (ne) gives `cnd`=0.
- OPq add, a=b=0x4000_0000_0000_0000 → `val_e`=0x8000_0000_0000_0000, `cc`=011. A following cmov ifun 2 (l) gives `cnd`=0 and `val_e`=`val_a`.
- OPq mul, a=3, b=−7 (W=64):
  - `in_ready` is low for exactly 64 cycles.
  - Result `val_e`=−21, `cc`=010.
  - Repeat with `cc_inhibit`=1: CC stays unchanged.
- call (icode 8) with `val_b`=0x100, then ret (icode 9) with `val_b`=0xF8 → `val_e`=0xF8, then 0x100. Holding `out_ready`=0 for 3 cycles keeps `val_e` stable and `in_ready`=0.
- `reset_n` pulsed low mid-multiply:
  - `out_valid`=0 and `cc`=100 after the reset edge.
  - A subsequent irmovq with `val_c`=0x55 completes in 1 cycle.
